// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: operand widths, rounding modes and
// the canonical quiet NaN.
package fpu_pkg;

    localparam int FP_W = 32;
    localparam int RM_W = 3;

    typedef enum logic [RM_W-1:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rm_e;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fpu_resp_fifo.sv
// Synchronous FIFO holding returned products for one requester. Pointers and
// occupancy are reset; storage is not, so the head is only meaningful when !empty.
module fpu_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fpu_mult_arbiter.sv
// Round-robin sharing of one non-stallable pipelined FP multiplier between
// NUM_REQ requesters; per-requester credits reserve a response slot for every issue.
module fpu_mult_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int MUL_LAT    = 5,
    parameter int RESP_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*FP_W-1:0]   req_a,
    input  logic [NUM_REQ*FP_W-1:0]   req_b,
    input  logic [NUM_REQ*RM_W-1:0]   req_rm,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [NUM_REQ*FP_W-1:0]   resp_data,
    output logic                      mul_req,
    output logic [FP_W-1:0]           mul_a,
    output logic [FP_W-1:0]           mul_b,
    output logic [RM_W-1:0]           mul_rm,
    input  logic [FP_W-1:0]           mul_out,
    input  logic                      mul_valid,
    output logic                      busy,
    output logic                      err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(RESP_DEPTH + 1);
    localparam int GW  = $clog2(MUL_LAT + 1);

    logic [NUM_REQ-1:0][CW-1:0]   cnt;
    logic [IDW-1:0]               last;
    logic [NUM_REQ-1:0]           eligible;
    logic [NUM_REQ-1:0]           grant;
    logic [IDW-1:0]               gnt_id;
    logic                         issue;

    logic [MUL_LAT-1:0]           tag_vld_p;
    logic [MUL_LAT-1:0][IDW-1:0]  tag_id_p;
    logic [GW-1:0]                ign_cnt;
    logic                         ign_active;
    logic                         cap_en;
    logic                         mismatch;

    logic [NUM_REQ-1:0]           fifo_push;
    logic [NUM_REQ-1:0]           fifo_pop;
    logic [NUM_REQ-1:0]           fifo_full;
    logic [NUM_REQ-1:0]           fifo_empty;
    logic [NUM_REQ-1:0][FP_W-1:0] fifo_dout;
    logic [NUM_REQ-1:0][CW-1:0]   fifo_cnt;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            eligible[i] = req_valid[i] && (cnt[i] < CW'(RESP_DEPTH));
    end

    // Search distance k = 1..NUM_REQ from the last winner; the first eligible index wins.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        issue  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!issue && eligible[i] && (i == (int'(last) + k) % NUM_REQ)) begin
                    issue    = 1'b1;
                    gnt_id   = IDW'(i);
                    grant[i] = 1'b1;
                end
            end
        end
        if (rst) begin
            grant  = '0;
            gnt_id = '0;
            issue  = 1'b0;
        end
    end

    assign req_ready = grant;
    assign mul_req   = issue;

    always_comb begin
        mul_a  = '0;
        mul_b  = '0;
        mul_rm = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mul_a  = req_a[i*FP_W +: FP_W];
                mul_b  = req_b[i*FP_W +: FP_W];
                mul_rm = req_rm[i*RM_W +: RM_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= IDW'(NUM_REQ - 1);
        end else if (issue) begin
            last <= gnt_id;
        end
    end

    // Issue stage -> tag pipeline p0..p(MUL_LAT-1), aligned with the core's own latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_p <= '0;
        end else begin
            tag_vld_p[0] <= issue;
            for (int s = 1; s < MUL_LAT; s++) tag_vld_p[s] <= tag_vld_p[s-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_id_p[0] <= gnt_id;
        for (int s = 1; s < MUL_LAT; s++) tag_id_p[s] <= tag_id_p[s-1];
    end

    // The core shares our reset, so its result strobe is untrustworthy until its pipe has flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ign_cnt <= GW'(MUL_LAT);
        end else if (ign_cnt != '0) begin
            ign_cnt <= ign_cnt - 1'b1;
        end
    end

    assign ign_active = (ign_cnt != '0);
    assign cap_en     = ~ign_active & mul_valid & tag_vld_p[MUL_LAT-1];
    assign mismatch   = ~ign_active & (mul_valid ^ tag_vld_p[MUL_LAT-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (mismatch) begin
            err <= 1'b1;
        end
    end

    // Capture stage -> per-requester response FIFOs.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_resp
        assign fifo_push[g] = cap_en && (tag_id_p[MUL_LAT-1] == IDW'(g)) && !fifo_full[g];
        assign fifo_pop[g]  = resp_valid[g] & resp_ready[g];
        assign resp_valid[g] = ~fifo_empty[g];
        assign resp_data[g*FP_W +: FP_W] = fifo_empty[g] ? '0 : fifo_dout[g];

        fpu_resp_fifo #(
            .DEPTH (RESP_DEPTH),
            .W     (FP_W)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[g]),
            .pop   (fifo_pop[g]),
            .din   (mul_out),
            .dout  (fifo_dout[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g]),
            .count (fifo_cnt[g])
        );
    end

    // Credits: operations in flight plus results still buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && !fifo_pop[i])      cnt[i] <= cnt[i] + 1'b1;
                else if (!grant[i] && fifo_pop[i]) cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    assign busy = (|tag_vld_p) | (|cnt) | (|fifo_cnt);

endmodule
